lse_simd_pipe: RTL

Parametrised, pipelined successor to the combinational 24-bit LSE unit. It carries LANES independent log-sum-exp lanes, each DATA_WIDTH bits, behind a valid/ready stream interface with backpressure. Two modes are supported: PAIR computes LSE(x,y) per beat; ACC reduces a packet of x beats per lane into one LSE result. It sits between the operand fetch stream and the PE result writeback.

---
 rtl/lse_pkg.sv | 29 ++
 rtl/lse_lane_kernel.sv | 54 +++++
 rtl/lse_simd_pipe.sv | 119 +++++++++++
 3 files changed

// File: rtl/lse_pkg.sv
// Shared mode encoding and fixed-point constant helpers for the LSE pipeline.
// Helpers return 64-bit values; callers size-cast them to their own width.
package lse_pkg;

  typedef enum logic {
    LSE_PAIR = 1'b0,
    LSE_ACC  = 1'b1
  } lse_mode_e;

  // Most negative code, used as log-domain minus infinity.
  function automatic longint lse_neg_inf(input int unsigned w);
    return -(longint'(1) << (w - 1));
  endfunction

  function automatic longint lse_pos_sat(input int unsigned w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // 1.0 shifted right by sh, i.e. 2^-sh in fixed point.
  function automatic longint lse_frac(input int unsigned f, input int unsigned sh);
    return (longint'(1) << f) >> sh;
  endfunction

  // Negative threshold -mag.0 in fixed point.
  function automatic longint lse_thr(input int unsigned mag, input int unsigned f);
    return -(longint'(mag) << f);
  endfunction

endpackage

// File: rtl/lse_lane_kernel.sv
// Combinational single-lane log-sum-exp: max plus a piecewise-constant correction,
// saturating at the positive limit.
module lse_lane_kernel
  import lse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FRAC_BITS  = 10
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  output logic [DATA_WIDTH-1:0] o_res,
  output logic                  o_ovf
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [W-1:0]        NegInf    = W'(lse_neg_inf(W));
  localparam logic signed [W:0]   PosSatX   = (W+1)'(lse_pos_sat(W));
  localparam logic signed [W:0]   ThrN8     = (W+1)'(lse_thr(8, FRAC_BITS));
  localparam logic signed [W:0]   ThrN4     = (W+1)'(lse_thr(4, FRAC_BITS));
  localparam logic signed [W:0]   ThrN2     = (W+1)'(lse_thr(2, FRAC_BITS));
  localparam logic signed [W:0]   CorrOne   = (W+1)'(lse_frac(FRAC_BITS, 0));
  localparam logic signed [W:0]   CorrHalf  = (W+1)'(lse_frac(FRAC_BITS, 1));
  localparam logic signed [W:0]   CorrEigth = (W+1)'(lse_frac(FRAC_BITS, 3));
  localparam logic signed [W:0]   CorrTiny  = (W+1)'(lse_frac(FRAC_BITS, 5));

  logic signed [W-1:0] w_a, w_b, w_l, w_s;
  logic signed [W:0]   w_d, w_corr, w_sum;

  assign w_a = i_a;
  assign w_b = i_b;

  always_comb begin
    w_l    = (w_a >= w_b) ? w_a : w_b;
    w_s    = (w_a >= w_b) ? w_b : w_a;
    // One extra bit keeps d and the sum exact across the full operand range.
    w_d    = {w_s[W-1], w_s} - {w_l[W-1], w_l};
    w_corr = CorrOne;
    if (w_s == NegInf)     w_corr = '0;
    else if (w_d == '0)    w_corr = CorrOne;
    else if (w_d < ThrN8)  w_corr = CorrTiny;
    else if (w_d < ThrN4)  w_corr = CorrEigth;
    else if (w_d < ThrN2)  w_corr = CorrHalf;
    w_sum  = {w_l[W-1], w_l} + w_corr;
    o_res  = w_sum[W-1:0];
    o_ovf  = 1'b0;
    if ((i_a == NegInf) && (i_b == NegInf)) begin
      o_res = NegInf;
    end else if (w_sum > PosSatX) begin
      o_res = PosSatX[W-1:0];
      o_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/lse_simd_pipe.sv
// Two-stage SIMD log-sum-exp pipeline with valid/ready handshakes, supporting
// per-beat pairs and per-packet accumulation.
module lse_simd_pipe
  import lse_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned FRAC_BITS  = 10,
  parameter int unsigned LANES      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        mode_i,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*DATA_WIDTH-1:0] in_x,
  input  logic [LANES*DATA_WIDTH-1:0] in_y,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*DATA_WIDTH-1:0] out_result,
  output logic [LANES-1:0]            out_ovf,
  output logic [LANES-1:0]            ovf_sticky,
  input  logic                        ovf_clr,
  output logic                        busy
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned VW = LANES * DATA_WIDTH;
  localparam logic [W-1:0]  NegInf    = W'(lse_neg_inf(W));
  localparam logic [VW-1:0] NegInfVec = {LANES{NegInf}};

  logic              r_s1_valid, r_s1_last, r_pkt_open, r_out_valid;
  lse_mode_e         r_s1_mode;
  logic [VW-1:0]     r_s1_x, r_s1_y, r_acc, r_out_result;
  logic [LANES-1:0]  r_acc_ovf, r_out_ovf, r_sticky;

  lse_mode_e         w_in_mode;
  logic              w_in_fire, w_s2_free, w_s1_emits, w_s1_adv, w_s2_load;
  logic [VW-1:0]     w_kern_a, w_kern_res;
  logic [LANES-1:0]  w_kern_ovf, w_pkt_ovf;

  // Only ACC packets stay open, so an open packet pins the mode to ACC.
  assign w_in_mode  = r_pkt_open ? LSE_ACC : lse_mode_e'(mode_i);
  assign w_in_fire  = in_valid && in_ready;
  assign w_s2_free  = !r_out_valid || out_ready;
  assign w_s1_emits = (r_s1_mode == LSE_PAIR) || r_s1_last;
  assign w_s1_adv   = r_s1_valid && (!w_s1_emits || w_s2_free);
  assign w_s2_load  = w_s1_adv && w_s1_emits;
  assign in_ready   = !r_s1_valid || w_s1_adv;
  assign w_kern_a   = (r_s1_mode == LSE_ACC) ? r_acc : r_s1_y;
  assign w_pkt_ovf  = w_kern_ovf | ((r_s1_mode == LSE_ACC) ? r_acc_ovf : '0);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    lse_lane_kernel #(
      .DATA_WIDTH (W),
      .FRAC_BITS  (FRAC_BITS)
    ) u_kernel (
      .i_a   (w_kern_a[g*W +: W]),
      .i_b   (r_s1_x[g*W +: W]),
      .o_res (w_kern_res[g*W +: W]),
      .o_ovf (w_kern_ovf[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_mode  <= LSE_PAIR;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_pkt_open <= 1'b0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_last  <= (w_in_mode == LSE_PAIR) || in_last;
      r_s1_mode  <= w_in_mode;
      r_s1_x     <= in_x;
      r_s1_y     <= in_y;
      r_pkt_open <= (w_in_mode == LSE_ACC) && !in_last;
    end else if (w_s1_adv) begin
      r_s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= NegInfVec;
      r_acc_ovf <= '0;
    end else if (w_s1_adv && (r_s1_mode == LSE_ACC)) begin
      r_acc     <= r_s1_last ? NegInfVec : w_kern_res;
      r_acc_ovf <= r_s1_last ? '0 : w_pkt_ovf;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= '0;
      r_sticky     <= '0;
    end else begin
      if (w_s2_load) begin
        r_out_valid  <= 1'b1;
        r_out_result <= w_kern_res;
        r_out_ovf    <= w_pkt_ovf;
      end else if (out_ready) begin
        r_out_valid  <= 1'b0;
      end
      r_sticky <= (ovf_clr ? '0 : r_sticky) | (w_s2_load ? w_pkt_ovf : '0);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_ovf    = r_out_ovf;
  assign ovf_sticky = r_sticky;
  assign busy       = r_pkt_open || r_s1_valid || r_out_valid;

endmodule
